uart_calc_sequencer: RTL
========================

// Module: uart_calc_sequencer
// PURPOSE
//  Parametrised keystroke sequencer for the UART calculator. Consumes ASCII bytes from the
//  UART receiver; builds decimal operands A/B and opcode for the combinational ALU.
//  Captures the ALU result on '=' and drives state for Bin2Dig/seven-seg/VGA.
//  Adds over the previous input controller: configurable width/digits, backspace, clear,
//  result chaining, repeat-equals and a sticky error state.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (unsigned)
//  DIGITS   4  max decimal digits accepted per operand
//  CHAIN    1  1: operator typed in RESULT loads result into A; 0: operator ignored there
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous, active-low reset
//  rx_data      in   8      received ASCII byte, valid only when rx_valid=1
//  rx_valid     in   1      one-cycle strobe per received byte
//  alu_result   in   WIDTH  ALU output for current op_a/op_b/opcode
//  alu_flag     in   1      ALU error (divide by zero / out of range)
//  op_a         out  WIDTH  operand A
//  op_b         out  WIDTH  operand B
//  opcode       out  4      1=add 2=sub 3=mul 4=div; 0 before any operator
//  result       out  WIDTH  captured result
//  state        out  2      0=ENTER_A 1=ENTER_B 2=RESULT 3=ERROR
//  digit_cnt    out  3      digits in the operand being entered (0..DIGITS)
//  entry_ovf    out  1      one-cycle pulse: a digit was rejected
// BEHAVIOUR
//  Reset: all outputs 0; state=ENTER_A. An asserted reset_n mid-entry clears all registers.
//  Key decode on rx_valid only; all updates are visible 1 cycle after the strobe.
//   '0'-'9' digit; '+','-','*','/' operator; '=' or 0x0D eval; 0x08 backspace;
//   'c','C',0x1B clear; any other byte is ignored with no state change.
//  Clear (any state): A=B=result=opcode=digit_cnt=0, state=ENTER_A. Clear has top priority.
//  Digit append: acc_next = acc*10 + d (shift-add, WIDTH+4 bit intermediate).
//   Rejected (acc unchanged, entry_ovf pulses) if digit_cnt==DIGITS or acc_next >= 2**WIDTH.
//   Accepted: digit_cnt += 1. A leading '0' counts as a digit.
//  Backspace: acc = acc/10 (constant divide), digit_cnt -= 1. It is a no-op at digit_cnt==0.
//   It is ignored in RESULT and ERROR.
//  ENTER_A: digit -> append to A. Operator -> opcode set, B=0, digit_cnt=0, go ENTER_B.
//   An operator with no digits uses A=0. Eval is ignored.
//  ENTER_B: digit -> append to B.
//   Operator with digit_cnt==0 replaces opcode. Operator with digit_cnt>0 is ignored.
//   Eval: if alu_flag -> ERROR (result=0). Else result=alu_result, go RESULT.
//   The ALU is sampled in the strobe cycle.
//  RESULT: digit -> A=d, B=0, opcode=0, digit_cnt=1, go ENTER_A.
//   Operator -> if CHAIN: A=result, B=0, opcode set, digit_cnt=0, go ENTER_B.
//   If CHAIN=0 the operator is ignored.
//   Eval (repeat): A=result with B and opcode kept; on the next cycle result=ALU(A,B).
//   Implement this as internal 1-cycle EVAL2 sub-step with state output held at 2. Strobes
//   arriving during that cycle are ignored. alu_flag during EVAL2 -> ERROR.
//  ERROR: all keys except clear are ignored. The outputs keep their last values apart from
//   result=0.
//  Subtraction underflow is left to the ALU flag; the sequencer does no extra width checks.
// TESTING
//  "12+34=" -> op_a=12, op_b=34, opcode=1, state=2, result=46 one cycle after '=' strobe.
//  DIGITS=4: "12345" -> op_a=1234, digit_cnt=4, entry_ovf pulse on '5'.
//   WIDTH=8: "300" -> op_a=30, entry_ovf pulse.
//  "123",0x08,"9" -> op_a=129. 0x08 at digit_cnt=0 -> no change.
//  "8/0=" with alu_flag=1 -> state=3. Then "5" ignored. Then 'c' -> state=0, all outputs 0.
//  CHAIN=1: "2+3=" then "*4=" -> result=20. Then "=" -> A=20, result=80 (repeat).
//  reset_n low for 1 cycle mid "45+6" -> every output 0 and state=0 immediately (async).
//   Then rx_valid at the same edge as reset release -> byte ignored.

Source files
------------

// File: rtl/uart_calc_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_calc_sequencer_if
// Bundles the signals between the UART calculator keystroke sequencer and its
// surroundings: the UART receiver byte stream, the combinational ALU and the
// display side (Bin2Dig / seven-seg / VGA).
//   rx_data/rx_valid      : received ASCII byte and its one-cycle strobe
//   alu_result/alu_flag   : ALU output and error flag for op_a/op_b/opcode
//   op_a/op_b/opcode      : operands and operator presented to the ALU
//   result/state          : captured result and sequencer state for display
//   digit_cnt/entry_ovf   : digits in current operand, rejected-digit pulse
// Modports: master = environment (UART rx + ALU + display), slave = sequencer.
// -----------------------------------------------------------------------------
interface uart_calc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_flag;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] result;
  logic [1:0]       state;
  logic [2:0]       digit_cnt;
  logic             entry_ovf;

  modport master (
    output rx_data, rx_valid, alu_result, alu_flag,
    input  op_a, op_b, opcode, result, state, digit_cnt, entry_ovf
  );

  modport slave (
    input  rx_data, rx_valid, alu_result, alu_flag,
    output op_a, op_b, opcode, result, state, digit_cnt, entry_ovf
  );
endinterface

// File: rtl/uart_calc_sequencer.sv
// -----------------------------------------------------------------------------
// uart_calc_sequencer
// Keystroke sequencer for the UART calculator. Decodes ASCII bytes into decimal
// operands A/B and an opcode for the external combinational ALU, captures the
// ALU result on evaluate, and supports backspace, clear, result chaining,
// repeat-equals and a sticky error state.
// Parameters:
//   WIDTH  : operand/result width (unsigned)
//   DIGITS : maximum decimal digits per operand
//   CHAIN  : 1 = operator typed in RESULT continues from the result
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset, clears every register
//   bus     : uart_calc_sequencer_if.slave (byte stream in, ALU in, operands,
//             result, state, digit count and overflow pulse out)
// -----------------------------------------------------------------------------
module uart_calc_sequencer #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4,
  parameter int CHAIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_calc_sequencer_if.slave  bus
);

  // Low two bits are the externally visible state code; EVAL2 reports RESULT.
  typedef enum logic [2:0] {
    S_ENTER_A = 3'b000,
    S_ENTER_B = 3'b001,
    S_RESULT  = 3'b010,
    S_ERROR   = 3'b011,
    S_EVAL2   = 3'b110
  } st_t;

  localparam logic [2:0]       MAX_DIG = 3'(DIGITS);
  localparam logic [WIDTH-1:0] TEN     = WIDTH'(10);

  st_t              st_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       opc_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       dcnt_q;
  logic             ovf_q;
  // Goes high one clock after reset release so a strobe coinciding with the
  // releasing edge is never decoded, whichever way that edge race resolves.
  logic             armed_q;

  // acc*10 + d as shift-add in a WIDTH+4 bit intermediate (cannot wrap).
  function automatic logic [WIDTH+3:0] append_digit(input logic [WIDTH-1:0] acc,
                                                    input logic [3:0]       d);
    logic [WIDTH+3:0] wide;
    wide = {4'b0000, acc};
    return (wide << 3) + (wide << 1) + {{WIDTH{1'b0}}, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Key decode
  // ---------------------------------------------------------------------------
  logic       is_digit, is_op, is_eval, is_bs, is_clr;
  logic [3:0] key_val;
  logic [3:0] key_opc;

  always_comb begin
    is_digit = 1'b0;
    is_op    = 1'b0;
    is_eval  = 1'b0;
    is_bs    = 1'b0;
    is_clr   = 1'b0;
    key_val  = bus.rx_data[3:0];
    key_opc  = 4'd0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_digit = 1'b1;
    end else begin
      case (bus.rx_data)
        8'h2B: begin is_op = 1'b1; key_opc = 4'd1; end  // '+'
        8'h2D: begin is_op = 1'b1; key_opc = 4'd2; end  // '-'
        8'h2A: begin is_op = 1'b1; key_opc = 4'd3; end  // '*'
        8'h2F: begin is_op = 1'b1; key_opc = 4'd4; end  // '/'
        8'h3D, 8'h0D:        is_eval = 1'b1;            // '=' or CR
        8'h08:               is_bs   = 1'b1;            // backspace
        8'h63, 8'h43, 8'h1B: is_clr  = 1'b1;            // 'c', 'C', ESC
        default: ;
      endcase
    end
  end

  // Edit arithmetic acts on whichever operand is currently being entered.
  logic [WIDTH-1:0] cur_acc;
  logic [WIDTH+3:0] app_val;
  logic             app_ok;
  logic [WIDTH-1:0] bs_val;

  always_comb begin
    cur_acc = (st_q == S_ENTER_B) ? b_q : a_q;
    app_val = append_digit(cur_acc, key_val);
    app_ok  = (dcnt_q < MAX_DIG) && (app_val[WIDTH+3:WIDTH] == 4'd0);
    bs_val  = cur_acc / TEN;
  end

  // ---------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= S_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= 4'd0;
      res_q   <= '0;
      dcnt_q  <= 3'd0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      ovf_q   <= 1'b0;
      if (st_q == S_EVAL2) begin
        // Second half of repeat-equals: ALU now sees the reloaded A.
        if (bus.alu_flag) begin
          res_q <= '0;
          st_q  <= S_ERROR;
        end else begin
          res_q <= bus.alu_result;
          st_q  <= S_RESULT;
        end
      end else if (armed_q && bus.rx_valid) begin
        if (is_clr) begin
          a_q    <= '0;
          b_q    <= '0;
          res_q  <= '0;
          opc_q  <= 4'd0;
          dcnt_q <= 3'd0;
          st_q   <= S_ENTER_A;
        end else begin
          case (st_q)
            S_ENTER_A: begin
              if (is_digit) begin
                if (app_ok) begin
                  a_q    <= app_val[WIDTH-1:0];
                  dcnt_q <= dcnt_q + 3'd1;
                end else begin
                  ovf_q <= 1'b1;
                end
              end else if (is_bs) begin
                if (dcnt_q != 3'd0) begin
                  a_q    <= bs_val;
                  dcnt_q <= dcnt_q - 3'd1;
                end
              end else if (is_op) begin
                opc_q  <= key_opc;
                b_q    <= '0;
                dcnt_q <= 3'd0;
                st_q   <= S_ENTER_B;
              end
            end
            S_ENTER_B: begin
              if (is_digit) begin
                if (app_ok) begin
                  b_q    <= app_val[WIDTH-1:0];
                  dcnt_q <= dcnt_q + 3'd1;
                end else begin
                  ovf_q <= 1'b1;
                end
              end else if (is_bs) begin
                if (dcnt_q != 3'd0) begin
                  b_q    <= bs_val;
                  dcnt_q <= dcnt_q - 3'd1;
                end
              end else if (is_op) begin
                // Operator only replaces the opcode before any B digit.
                if (dcnt_q == 3'd0) opc_q <= key_opc;
              end else if (is_eval) begin
                if (bus.alu_flag) begin
                  res_q <= '0;
                  st_q  <= S_ERROR;
                end else begin
                  res_q <= bus.alu_result;
                  st_q  <= S_RESULT;
                end
              end
            end
            S_RESULT: begin
              if (is_digit) begin
                a_q    <= WIDTH'(key_val);
                b_q    <= '0;
                opc_q  <= 4'd0;
                dcnt_q <= 3'd1;
                st_q   <= S_ENTER_A;
              end else if (is_op) begin
                if (CHAIN != 0) begin
                  a_q    <= res_q;
                  b_q    <= '0;
                  opc_q  <= key_opc;
                  dcnt_q <= 3'd0;
                  st_q   <= S_ENTER_B;
                end
              end else if (is_eval) begin
                a_q  <= res_q;
                st_q <= S_EVAL2;
              end
            end
            default: ;  // ERROR: only clear escapes
          endcase
        end
      end
    end
  end

  assign bus.op_a      = a_q;
  assign bus.op_b      = b_q;
  assign bus.opcode    = opc_q;
  assign bus.result    = res_q;
  assign bus.state     = st_q[1:0];
  assign bus.digit_cnt = dcnt_q;
  assign bus.entry_ovf = ovf_q;

endmodule
